phys_reg_free_list: RTL and testbench

Circular free list of physical register IDs that feeds the rename/dispatch stage. Each dispatch pop hands out SS fresh destination tags. Each commit returns the displaced physical registers, at up to SS per cycle. The empty flag feeds the stall logic that gates the instruction-queue pop.

---
 rtl/phys_reg_free_list_pkg.sv | 27 ++
 rtl/phys_reg_free_list_push_compact.sv | 29 ++
 rtl/phys_reg_free_list.sv | 115 +++++++++++
 tb/tb_phys_reg_free_list.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/phys_reg_free_list_pkg.sv
// Shared constants and types for the physical register free list and the
// rename/dispatch blocks that consume its tags.
package phys_reg_free_list_pkg;

    // Superscalar width: tags popped per dispatch, tags returned per commit.
    localparam int SS         = 2;
    // Physical register file size and the architectural subset mapped at reset.
    localparam int PR_ENTRIES = 64;
    localparam int ARCH_REGS  = 32;
    // Free list capacity: every physical register not mapped at reset.
    localparam int FL_DEPTH   = PR_ENTRIES - ARCH_REGS;

    // Derived widths.
    localparam int PR_W       = $clog2(PR_ENTRIES);   // physical register tag
    localparam int IDX_W      = $clog2(FL_DEPTH);     // RAM index
    localparam int PTR_W      = IDX_W + 1;            // pointer incl. wrap bit
    localparam int LANE_CNT_W = $clog2(SS + 1);       // 0..SS accepted lanes

    typedef logic [PR_W-1:0] pr_id_t;

    // Tag held by free list entry k straight out of reset: the PRs just
    // above the architectural range, in ascending order.
    function automatic pr_id_t reset_tag(input int k);
        return pr_id_t'(ARCH_REGS + k);
    endfunction

endpackage

// File: rtl/phys_reg_free_list_push_compact.sv
// Commit-lane compaction for the free list: decides which return lanes
// carry a recyclable tag and gives each accepted lane its slot offset from
// the tail, so accepted tags land contiguously in lane order.
module free_list_push_compact
    import phys_reg_free_list_pkg::*;
(
    input  logic [SS-1:0]                 push_valid,
    input  logic [SS-1:0][PR_W-1:0]       push_pr,
    output logic [SS-1:0]                 accept,
    output logic [SS-1:0][LANE_CNT_W-1:0] rank,
    output logic [LANE_CNT_W-1:0]         n_push
);

    // Accept lanes with a non-zero tag (PR0 is never recycled) and assign
    // each one the count of accepted lanes below it as its rank.
    always_comb begin
        logic [LANE_CNT_W-1:0] acc;
        acc    = '0;
        accept = '0;
        rank   = '0;
        for (int i = 0; i < SS; i++) begin
            accept[i] = push_valid[i] && (push_pr[i] != '0);
            rank[i]   = acc;
            acc       = acc + LANE_CNT_W'(accept[i]);
        end
        n_push = acc;
    end

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags. Dispatch pops SS fresh
// destination tags at a time; commit returns displaced tags on up to SS
// lanes per cycle. Head/tail carry a wrap bit so full and empty differ.
//
// Interface semantics: fl_empty is the ready for pop. A pop is taken only
// when pop=1 and fl_empty=0 in the same cycle; free_rat_rds holds the SS
// tags that such a pop consumes at the next posedge. push_valid[i] is a
// one-cycle strobe with no back-pressure: a lane is taken when its tag is
// non-zero and the cycle does not overflow; otherwise it is dropped and,
// for overflow, recorded in the sticky overflow_err.
module phys_reg_free_list
    import phys_reg_free_list_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pop,
    output logic [SS-1:0][PR_W-1:0]  free_rat_rds,
    output logic                     fl_empty,
    output logic [PTR_W-1:0]         fl_count,
    input  logic [SS-1:0]            push_valid,
    input  logic [SS-1:0][PR_W-1:0]  push_pr,
    output logic                     underflow_err,
    output logic                     overflow_err
);

    localparam int CALC_W = PTR_W + 1;
    localparam logic [PTR_W-1:0]  SS_P     = PTR_W'(SS);
    localparam logic [PTR_W-1:0]  TAIL_RST = PTR_W'(FL_DEPTH);
    localparam logic [CALC_W-1:0] DEPTH_C  = CALC_W'(FL_DEPTH);

    pr_id_t                       mem [FL_DEPTH];
    logic [PTR_W-1:0]             head;
    logic [PTR_W-1:0]             tail;

    logic [SS-1:0]                accept;
    logic [SS-1:0][LANE_CNT_W-1:0] rank;
    logic [LANE_CNT_W-1:0]        n_push;

    logic                         pop_ok;
    logic [CALC_W-1:0]            next_count;
    logic                         push_overflow;

    free_list_push_compact u_push_compact (
        .push_valid (push_valid),
        .push_pr    (push_pr),
        .accept     (accept),
        .rank       (rank),
        .n_push     (n_push)
    );

    // Occupancy comes straight from the pointers; modular subtraction
    // handles wrap, and the extra pointer bit separates full from empty.
    assign fl_count = tail - head;
    assign fl_empty = (fl_count < SS_P);
    assign pop_ok   = pop && !fl_empty;

    // Post-edge occupancy, computed one bit wider so a push into a full
    // list is seen as exceeding capacity instead of wrapping to zero.
    always_comb begin
        next_count = {1'b0, fl_count};
        if (pop_ok) begin
            next_count = next_count - {1'b0, SS_P};
        end
        next_count    = next_count + CALC_W'(n_push);
        push_overflow = (next_count > DEPTH_C);
    end

    // Present the next SS tags from the head; no bypass of same-cycle
    // pushes, and lanes read the RAM even when the list is short.
    always_comb begin
        for (int i = 0; i < SS; i++) begin
            free_rat_rds[i] = mem[head[IDX_W-1:0] + IDX_W'(i)];
        end
    end

    // Pointer and sticky error state; an overflowing cycle drops every
    // push but still lets a valid pop through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head          <= '0;
            tail          <= TAIL_RST;
            underflow_err <= 1'b0;
            overflow_err  <= 1'b0;
        end else begin
            if (pop_ok) begin
                head <= head + SS_P;
            end
            if (pop && fl_empty) begin
                underflow_err <= 1'b1;
            end
            if (push_overflow) begin
                overflow_err <= 1'b1;
            end else begin
                tail <= tail + PTR_W'(n_push);
            end
        end
    end

    // Tag storage: reset reloads the unmapped PRs, commits write accepted
    // tags at tail + rank so they stay contiguous in lane order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < FL_DEPTH; k++) begin
                mem[k] <= reset_tag(k);
            end
        end else if (!push_overflow) begin
            for (int i = 0; i < SS; i++) begin
                if (accept[i]) begin
                    mem[tail[IDX_W-1:0] + IDX_W'(rank[i])] <= push_pr[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: a driver issues one cycle of
// stimulus per step together with the hand-computed outputs expected in
// that cycle; a negedge monitor pops and compares them.
module tb_phys_reg_free_list;

  logic             clk;
  logic             rst_n;
  logic             pop;
  logic [1:0][5:0]  free_rat_rds;
  logic             fl_empty;
  logic [5:0]       fl_count;
  logic [1:0]       push_valid;
  logic [1:0][5:0]  push_pr;
  logic             underflow_err;
  logic             overflow_err;

  // {uf, of, empty, count[5:0], rd1[5:0], rd0[5:0]}
  logic [20:0] exp_q[$];
  string       name_q[$];
  int          checks;
  int          passes;

  phys_reg_free_list dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pop           (pop),
    .free_rat_rds  (free_rat_rds),
    .fl_empty      (fl_empty),
    .fl_count      (fl_count),
    .push_valid    (push_valid),
    .push_pr       (push_pr),
    .underflow_err (underflow_err),
    .overflow_err  (overflow_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] pack(input logic uf, input logic of_e,
                                       input logic emp, input logic [5:0] cnt,
                                       input logic [5:0] rd0, input logic [5:0] rd1);
    return {uf, of_e, emp, cnt, rd1, rd0};
  endfunction

  // driver: drive this cycle's inputs and record what the outputs must
  // show during this cycle (state left by the previous steps)
  task automatic step(input logic p, input logic [1:0] pv,
                      input logic [5:0] pr0, input logic [5:0] pr1,
                      input logic [5:0] e_cnt, input logic e_emp,
                      input logic [5:0] e_rd0, input logic [5:0] e_rd1,
                      input logic e_uf, input logic e_of, input string nm);
    @(posedge clk);
    #1;
    pop        = p;
    push_valid = pv;
    push_pr[0] = pr0;
    push_pr[1] = pr1;
    exp_q.push_back(pack(e_uf, e_of, e_emp, e_cnt, e_rd0, e_rd1));
    name_q.push_back(nm);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [20:0] e;
      logic [20:0] a;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = pack(underflow_err, overflow_err, fl_empty, fl_count,
                free_rat_rds[0], free_rat_rds[1]);
      checks++;
      if (a === e) begin
        passes++;
      end else begin
        $display("FAIL %s: got cnt=%0d emp=%0b rds={%0d,%0d} uf=%0b of=%0b, expected cnt=%0d emp=%0b rds={%0d,%0d} uf=%0b of=%0b",
                 nm, a[17:12], a[18], a[5:0], a[11:6], a[20], a[19],
                 e[17:12], e[18], e[5:0], e[11:6], e[20], e[19]);
      end
    end
  end

  initial begin
    checks     = 0;
    passes     = 0;
    rst_n      = 1'b0;
    pop        = 1'b0;
    push_valid = 2'b00;
    push_pr[0] = '0;
    push_pr[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // reset contents, no activity
    step(0, 2'b00, 0, 0, 32, 0, 32, 33, 0, 0, "reset_idle");

    // drain the list two tags per cycle
    for (int k = 0; k < 16; k++) begin
      step(1, 2'b00, 0, 0, 6'(32 - 2*k), 0, 6'(32 + 2*k), 6'(33 + 2*k), 0, 0, "pop_drain");
    end

    // now empty; this pop must be refused
    step(1, 2'b00, 0, 0, 0, 1, 32, 33, 0, 0, "empty_after_drain");
    // underflow recorded, head unchanged; push {5,7}
    step(0, 2'b11, 5, 7, 0, 1, 32, 33, 1, 0, "underflow_set");
    // lane 1 only: 9
    step(0, 2'b10, 11, 9, 2, 0, 5, 7, 1, 0, "push_5_7");
    // lane 0 carries PR0, lane 1 carries 4: only 4 stored
    step(0, 2'b11, 0, 4, 3, 0, 5, 7, 1, 0, "push_lane1_only");
    step(1, 2'b00, 0, 0, 4, 0, 5, 7, 1, 0, "pr0_dropped");
    step(1, 2'b00, 0, 0, 2, 0, 9, 4, 1, 0, "compacted_9_4");
    // empty again (head at index 4); load {40,41}
    step(0, 2'b11, 40, 41, 0, 1, 36, 37, 1, 0, "empty_again");

    // steady pop+push at count 2, long enough to wrap both pointers
    for (int j = 0; j < 20; j++) begin
      if (j == 0) begin
        step(1, 2'b11, 6'(10 + 2*j), 6'(11 + 2*j), 2, 0, 40, 41, 1, 0, "poppush_40_41");
      end else begin
        step(1, 2'b11, 6'(10 + 2*j), 6'(11 + 2*j), 2, 0, 6'(8 + 2*j), 6'(9 + 2*j), 1, 0, "poppush_wrap");
      end
    end

    // fill to capacity with no pops
    for (int j = 0; j < 15; j++) begin
      step(0, 2'b11, 6'(20 + 2*j), 6'(21 + 2*j), 6'(2 + 2*j), 0, 48, 49, 1, 0, "fill");
    end
    // full: push {3,4} must be dropped
    step(0, 2'b11, 3, 4, 32, 0, 48, 49, 1, 0, "full_before_ovf");
    // overflow recorded, count held; start popping
    step(1, 2'b00, 0, 0, 32, 0, 48, 49, 1, 1, "overflow_set");

    // asynchronous reset mid-pop, checked before any further posedge
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.push_back(pack(0, 0, 0, 32, 32, 33));
    name_q.push_back("async_reset");
    @(posedge clk);
    #1;
    pop   = 1'b0;
    rst_n = 1'b1;
    step(0, 2'b00, 0, 0, 32, 0, 32, 33, 0, 0, "after_reset");
    step(0, 2'b00, 0, 0, 32, 0, 32, 33, 0, 0, "after_reset_hold");

    // let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d expectations left, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
